// File: rtl/serial_adder_if.sv
// Handshake and result bundle for serial_adder; the optional ovf wire
// exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
`else
    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
`endif
endinterface

// File: rtl/serial_adder.sv
// Purpose: digit-serial adder, a + b + cin over WIDTH bits, DIGIT bits per clock (ovf via SERIAL_ADD_OVF_EN).
// Latency: NSTEPS+1 edges from accepted start to the done pulse; back-to-back starts accepted in DONE.
// Backpressure: start is accepted only in IDLE/DONE; a start during RUN is dropped, not queued.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  io
);

    localparam int NSTEPS = WIDTH / DIGIT;
    localparam int CW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;

    if (DIGIT < 1) begin : g_bad_digit
        $error("serial_adder: DIGIT must be at least 1");
    end else if (DIGIT > WIDTH) begin : g_bad_range
        $error("serial_adder: DIGIT must not exceed WIDTH");
    end else if ((WIDTH % DIGIT) != 0) begin : g_bad_mult
        $error("serial_adder: WIDTH must be a multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic [DIGIT:0]   digit;
    logic [WIDTH-1:0] res_nxt;
    logic             accept;
    logic             last_step;

    assign accept    = io.start && ((state_q == IDLE) || (state_q == DONE));
    assign last_step = (state_q == RUN) && (cnt_q == CW'(NSTEPS - 1));

    // One digit slice; completed digits enter the result from the top so the
    // least significant digit lands at bit 0 after NSTEPS shifts.
    always_comb begin
        digit   = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]}
                + (DIGIT+1)'(carry_q);
        res_nxt = res_sr >> DIGIT;
        res_nxt[WIDTH-1 -: DIGIT] = digit[DIGIT-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (io.start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = io.start ? RUN : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        io.busy = (state_q == RUN);
        io.done = (state_q == DONE);
        io.sum  = sum_q;
        io.cout = cout_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_sr    <= io.a;
            b_sr    <= io.b;
            res_sr  <= '0;
            carry_q <= io.cin;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            a_sr    <= a_sr >> DIGIT;
            b_sr    <= b_sr >> DIGIT;
            res_sr  <= res_nxt;
            carry_q <= digit[DIGIT];
            cnt_q   <= cnt_q + CW'(1);
        end
    end

    // Visible results move only on the RUN->DONE edge and otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (last_step) begin
            sum_q  <= res_nxt;
            cout_q <= digit[DIGIT];
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q;
    logic msb_cin;

    // Carry into the MSB recovered from the top bit of the final slice.
    assign msb_cin = a_sr[DIGIT-1] ^ b_sr[DIGIT-1] ^ digit[DIGIT-1];
    assign io.ovf  = ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (last_step) begin
            ovf_q <= msb_cin ^ digit[DIGIT];
        end
    end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: a DIGIT=1 and a DIGIT=4 instance (WIDTH=8),
// directed vectors with hand-computed results.
module tb_serial_adder;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(W)) i0 ();
    serial_adder_if #(.WIDTH(W)) i1 ();

    serial_adder #(.WIDTH(W), .DIGIT(1)) u0 (.clk(clk), .rst(rst), .io(i0));
    serial_adder #(.WIDTH(W), .DIGIT(4)) u1 (.clk(clk), .rst(rst), .io(i1));

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0;
    exp_t e1;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] held_sum0  = '0;
    logic [W-1:0] held_sum1  = '0;
    logic         held_cout0 = 1'b0;
    logic         held_cout1 = 1'b0;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endfunction

    function automatic void flag(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s", nm);
    endfunction

    // Monitors: pop on every done pulse; otherwise the result must hold.
    always @(negedge clk) begin
        if (rst) begin
            held_sum0  = '0;
            held_cout0 = 1'b0;
        end else if (i0.done) begin
            if (q0.size() == 0) begin
                flag("d1_unexpected_done");
            end else begin
                e0 = q0.pop_front();
                check("d1_sum", 32'(i0.sum), 32'(e0.sum));
                check("d1_cout", 32'(i0.cout), 32'(e0.cout));
`ifdef SERIAL_ADD_OVF_EN
                check("d1_ovf", 32'(i0.ovf), 32'(e0.ovf));
`endif
                held_sum0  = e0.sum;
                held_cout0 = e0.cout;
            end
        end else begin
            check("d1_hold_sum", 32'(i0.sum), 32'(held_sum0));
            check("d1_hold_cout", 32'(i0.cout), 32'(held_cout0));
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            held_sum1  = '0;
            held_cout1 = 1'b0;
        end else if (i1.done) begin
            if (q1.size() == 0) begin
                flag("d4_unexpected_done");
            end else begin
                e1 = q1.pop_front();
                check("d4_sum", 32'(i1.sum), 32'(e1.sum));
                check("d4_cout", 32'(i1.cout), 32'(e1.cout));
`ifdef SERIAL_ADD_OVF_EN
                check("d4_ovf", 32'(i1.ovf), 32'(e1.ovf));
`endif
                held_sum1  = e1.sum;
                held_cout1 = e1.cout;
            end
        end else begin
            check("d4_hold_sum", 32'(i1.sum), 32'(held_sum1));
            check("d4_hold_cout", 32'(i1.cout), 32'(held_cout1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one start for a cycle, push its expected result, then scramble inputs.
    task automatic issue(input int u, input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic [W-1:0] es, input logic ec, input logic eo);
        exp_t e;
        e = '{sum: es, cout: ec, ovf: eo};
        if (u == 0) begin
            q0.push_back(e);
            i0.start = 1'b1; i0.a = a; i0.b = b; i0.cin = c;
        end else begin
            q1.push_back(e);
            i1.start = 1'b1; i1.a = a; i1.b = b; i1.cin = c;
        end
        tick();
        if (u == 0) begin
            i0.start = 1'b0; i0.a = 8'($urandom); i0.b = 8'($urandom); i0.cin = 1'($urandom);
        end else begin
            i1.start = 1'b0; i1.a = 8'($urandom); i1.b = 8'($urandom); i1.cin = 1'($urandom);
        end
    endtask

    // Count busy cycles until done shows; leaves the bench in the done cycle.
    task automatic wait_done(input int u, input int nbusy, input string nm);
        int  busy_cyc = 0;
        bit  seen     = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if ((u == 0) ? i0.done : i1.done) begin
                seen = 1;
            end else begin
                if ((u == 0) ? i0.busy : i1.busy) busy_cyc++;
                tick();
            end
        end
        if (!seen) flag({nm, "_timeout_no_done"});
        else       check({nm, "_busy_cycles"}, 32'(busy_cyc), 32'(nbusy));
    endtask

    task automatic run(input int u, input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic [W-1:0] es, input logic ec, input logic eo,
                       input string nm, input int gap);
        issue(u, a, b, c, es, ec, eo);
        wait_done(u, (u == 0) ? 8 : 2, nm);
        for (int g = 0; g < gap; g++) tick();
    endtask

    initial begin
        rst = 1'b1;
        i0.start = 1'b0; i0.a = '0; i0.b = '0; i0.cin = 1'b0;
        i1.start = 1'b0; i1.a = '0; i1.b = '0; i1.cin = 1'b0;
        tick();
        check("rst_d1_busy", 32'(i0.busy), 0);
        check("rst_d1_done", 32'(i0.done), 0);
        check("rst_d1_sum",  32'(i0.sum),  0);
        check("rst_d1_cout", 32'(i0.cout), 0);
        check("rst_d4_busy", 32'(i1.busy), 0);
        check("rst_d4_sum",  32'(i1.sum),  0);
        tick();
        rst = 1'b0;
        tick();

        // DIGIT=1: idle gaps between operations.
        run(0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, "d1_5a_3c", 1);
        run(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "d1_ff_01", 1);
        run(0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, "d1_ff_00_c", 2);
        run(0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "d1_zero", 1);
        run(0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "d1_7f_01", 1);
        run(0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "d1_80_80", 1);
        run(0, 8'h40, 8'h20, 1'b0, 8'h60, 1'b0, 1'b0, "d1_40_20", 0);
        // Back-to-back from DONE on DIGIT=1.
        run(0, 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, "d1_a5_5a_c", 2);

        // DIGIT=4: first from IDLE, the rest restarted in the DONE cycle.
        run(1, 8'hF0, 8'h10, 1'b0, 8'h00, 1'b1, 1'b0, "d4_f0_10", 0);
        run(1, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, "d4_12_34", 0);
        run(1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "d4_ff_ff_c", 0);
        run(1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "d4_7f_01", 0);
        run(1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "d4_80_80", 3);

        // Start during RUN must be dropped: one done, original result.
        issue(0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        i0.start = 1'b1; i0.a = 8'h01; i0.b = 8'h01; i0.cin = 1'b0;
        tick();
        i0.start = 1'b0;
        wait_done(0, 4, "d1_ignored_start");
        for (int g = 0; g < 12; g++) tick();

        // Reset in the middle of an operation.
        issue(0, 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(i0.busy), 0);
        check("abort_done", 32'(i0.done), 0);
        check("abort_sum",  32'(i0.sum),  0);
        check("abort_cout", 32'(i0.cout), 0);
`ifdef SERIAL_ADD_OVF_EN
        check("abort_ovf",  32'(i0.ovf),  0);
`endif
        q0.delete();
        tick();
        tick();
        rst = 1'b0;
        for (int g = 0; g < 12; g++) begin
            tick();
            if (g % 4 == 0) check("abort_stays_idle", 32'(i0.busy), 0);
        end
        run(0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, "d1_after_abort", 2);

        check("d1_queue_drained", 32'(q0.size()), 0);
        check("d4_queue_drained", 32'(q1.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised multi-cycle successor to the single-bit half adder: adds two WIDTH-bit operands plus carry-in.
- Processes DIGIT bits per clock using an internal DIGIT-bit adder slice and a registered carry.
- Start/busy/done handshake; result registers hold until the next accepted start.
- Used where area matters more than latency, and as the team's reference sequential arithmetic block.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be a multiple of DIGIT.
- DIGIT, 1, bits added per clock; 1 <= DIGIT <= WIDTH.
- NSTEPS (localparam), WIDTH/DIGIT, number of RUN cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on the clock edge; accepted only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; sum and cout are valid from this cycle on.
- sum  output  WIDTH  result register.
- cout  output  1  carry-out register.
- ovf  output  1  signed overflow; present only when SERIAL_ADD_OVF_EN is defined.

Behaviour:
- Reset (async assert, any state): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; internal shift registers, carry and step counter cleared.
- Reset release: takes effect on the first clock edge after rst deasserts.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 at edge E0 captures a, b and cin into the operand shift registers and the carry register; cnt=0; next state RUN.
- RUN, each edge:
  - digit = A[DIGIT-1:0] + B[DIGIT-1:0] + carry, computed at DIGIT+1 bits.
  - Low DIGIT bits shift into the top of the internal result shift register; the bit at index DIGIT becomes the new carry.
  - A and B shift right by DIGIT; cnt increments.
- RUN exit: on the edge where cnt == NSTEPS-1, copy the completed result into sum, copy the final carry into cout, next state DONE.
- Timing: busy is high from E0 to E(NSTEPS); done is high for exactly one cycle after E(NSTEPS). Start-to-done latency is NSTEPS+1 edges.
- DONE: done=1. With start=1, the new operands are captured and the next state is RUN (back-to-back, no IDLE gap); otherwise the next state is IDLE.
- start while in RUN is ignored and not queued; the operation in flight is unaffected.
- Inputs a, b and cin may change freely after the accepting edge.
- sum and cout hold the previous result throughout IDLE and RUN. They update only on the RUN-to-DONE edge.
- Arithmetic is unsigned modulo 2^WIDTH, with cout as the WIDTH-th bit. Results must match a+b+cin exactly.
- Reset mid-RUN aborts the operation: done never pulses, and sum/cout/ovf are cleared.
- Elaboration fails (generate-time $error) if WIDTH % DIGIT != 0 or DIGIT < 1.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- Defined: port ovf exists. ovf = carry into the MSB XOR cout, i.e. two's-complement overflow. It is registered and updated together with sum/cout, and reset to 0.
- When DIGIT > 1, the carry into the MSB is taken from within the final digit slice.
- Undefined: no ovf port and no related logic; all other behaviour is identical.

Test Plan:
- WIDTH=8, DIGIT=1: rst pulse, then start with a=0x5A, b=0x3C, cin=0 -> busy high 8 cycles; done pulses once; sum=0x96, cout=0.
- WIDTH=8, DIGIT=1: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1. Then a=0x00, b=0x00, cin=0 -> sum=0x00, cout=0.
- WIDTH=8, DIGIT=4: a=0xF0, b=0x10 -> busy 2 cycles; sum=0x00, cout=1. Also assert start again in the DONE cycle with a=0x12, b=0x34 -> no IDLE gap; sum=0x46 two cycles later.
- Start while busy: pulse start with a=0x01, b=0x01 during RUN of 0x5A+0x3C -> ignored; result stays 0x96, and only one done pulse occurs.
- Reset mid-RUN: assert rst on cycle 4 of an 8-cycle add -> busy, done, sum and cout go to 0 immediately; no done pulse follows. The next start completes normally.
- SERIAL_ADD_OVF_EN defined, WIDTH=8: 0x7F+0x01 -> sum=0x80, ovf=1. 0x80+0x80 -> sum=0x00, cout=1, ovf=1. 0x40+0x20 -> ovf=0.
